hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_WIDTH, default 32: width of each performance counter.
REQ-002 Parameter MAX_STALL, default 4: count of consecutive data-stall cycles at which hang_o sets.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 stall_i  input  2  hazard code from the hazard detector: 00 none, 01 data (load-use), 10 control (taken branch/jump in EX), 11 treated as 01.
REQ-006 pc_en_o  output  1  PC register load enable.
REQ-007 ifid_en_o, idex_en_o  output  1 each  IF/ID and ID/EX pipeline register enables.
REQ-008 ifid_flush_o, idex_flush_o, exmem_flush_o  output  1 each  load a bubble (NOP, valid=0) into the named register.
REQ-009 vld_o  output  4  stage valid bits {WB,MEM,EX,ID} = vld_o[3:0].
REQ-010 state_o  output  2  FSM state: 00 RUN, 01 DSTALL, 10 CFLUSH.
REQ-011 hang_o  output  1  sticky consecutive-stall watchdog flag.
REQ-012 stall_cnt_o, flush_cnt_o, retire_cnt_o  output  CNT_WIDTH each  present only with HAZARD_PERF_EN.

Function
REQ-013 Effective code eff: stall_i, except 11 becomes 01, and 10 becomes 00 while state is CFLUSH (EX holds a bubble).
REQ-014 Controls are combinational from eff, valid in the same cycle, no registered latency.
REQ-015 eff=00: pc_en_o, ifid_en_o, idex_en_o = 1; all flushes = 0.
REQ-016 eff=01: pc_en_o, ifid_en_o, idex_en_o = 0; exmem_flush_o = 1; other flushes 0.
REQ-017 eff=10: pc_en_o, ifid_en_o, idex_en_o = 1; ifid_flush_o = idex_flush_o = 1; exmem_flush_o = 0.
REQ-018 Flush overrides enable on the same register.
REQ-019 FSM next state: eff=01 -> DSTALL; eff=10 -> CFLUSH; eff=00 -> RUN; identical rule from every state.
REQ-020 CFLUSH lasts one cycle unless eff=01 arrives, which moves to DSTALL.
REQ-021 Valid pipeline update per edge: ID <= ifid_flush_o ? 0 : (ifid_en_o ? 1 : ID); EX <= idex_flush_o ? 0 : (idex_en_o ? ID : EX); MEM <= exmem_flush_o ? 0 : EX; WB <= MEM.
REQ-022 Stall run counter: width sufficient for MAX_STALL; increments each cycle with eff=01, saturates at MAX_STALL, clears on any cycle with eff != 01.
REQ-023 hang_o sets on the edge where the run counter reaches MAX_STALL; held until reset; no effect on control outputs.
REQ-024 MAX_STALL=1: hang_o sets after the first data-stall cycle.

Reset
REQ-025 rst_ni low asynchronously forces state RUN, vld_o=0000, run counter 0, hang_o=0, all perf counters 0.
REQ-026 During reset, control outputs follow REQ-015 to REQ-017 from stall_i, with state taken as RUN.
REQ-027 Reset asserted mid-stall or mid-flush aborts it; first edge after release behaves as from RUN with empty pipeline.

Configuration
REQ-028 Macro HAZARD_PERF_EN defined: stall_cnt_o increments per eff=01 cycle; flush_cnt_o increments per eff=10 cycle; retire_cnt_o increments per edge with vld_o[3]=1.
REQ-029 All perf counters wrap modulo 2^CNT_WIDTH.
REQ-030 HAZARD_PERF_EN undefined: the three counter ports and their logic are absent; all other behaviour is identical.

Verification
REQ-031 Reset release, stall_i=00 for 5 cycles -> vld_o walks 0001, 0011, 0111, 1111, 1111; state_o=00 throughout.
REQ-032 Steady state, stall_i=01 for 1 cycle -> that cycle pc_en_o=0, exmem_flush_o=1; next cycle state_o=01, vld_o[2]=0; cycle after, vld_o[3]=0.
REQ-033 stall_i=10 then 10 again -> first cycle ifid_flush_o=idex_flush_o=1, state_o becomes 10; second cycle flushes 0 (ignored), state_o returns to 00; vld_o[1:0]=00 after the first edge.
REQ-034 MAX_STALL=4, stall_i=01 for 4 cycles, then 00 -> hang_o=1 after the 4th edge and stays 1; 3 cycles of 01 leave hang_o=0.
REQ-035 stall_i=11 -> identical outputs to 01; with HAZARD_PERF_EN, stall_cnt_o increments by 1.
REQ-036 rst_ni pulsed low mid-DSTALL -> state_o=00, vld_o=0000, hang_o=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush steering, stage valids, hang watchdog.
// Optional performance counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
  parameter int CNT_WIDTH = 32,
  parameter int MAX_STALL = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] stall_i,
  output logic       pc_en_o,
  output logic       ifid_en_o,
  output logic       idex_en_o,
  output logic       ifid_flush_o,
  output logic       idex_flush_o,
  output logic       exmem_flush_o,
  output logic [3:0] vld_o,
  output logic [1:0] state_o,
  output logic       hang_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o,
  output logic [CNT_WIDTH-1:0] retire_cnt_o
`endif
);

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DSTALL = 2'b01,
    CFLUSH = 2'b10
  } state_t;

  localparam int RW = $clog2(MAX_STALL + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL);

  state_t        state;
  logic          is_data;
  logic          is_ctrl;
  logic [RW-1:0] run_cnt;
  logic [RW-1:0] run_nxt;

  assign state_o = state;

  // Effective hazard: 11 acts as data; a control hazard is a bubble in CFLUSH.
  always_comb begin
    is_data = stall_i[0];
    is_ctrl = (stall_i == 2'b10) && (state != CFLUSH);
  end

  // Stage enables and bubble injection, same-cycle from the hazard.
  always_comb begin
    pc_en_o       = 1'b1;
    ifid_en_o     = 1'b1;
    idex_en_o     = 1'b1;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    exmem_flush_o = 1'b0;
    unique case (1'b1)
      is_data: begin
        pc_en_o       = 1'b0;
        ifid_en_o     = 1'b0;
        idex_en_o     = 1'b0;
        exmem_flush_o = 1'b1;
      end
      is_ctrl: begin
        ifid_flush_o = 1'b1;
        idex_flush_o = 1'b1;
      end
      default: ;
    endcase
  end

  // Hazard FSM: next state follows the effective hazard from any state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= RUN;
    end else begin
      unique case (1'b1)
        is_data: state <= DSTALL;
        is_ctrl: state <= CFLUSH;
        default: state <= RUN;
      endcase
    end
  end

  // Stage valid bits; a flush beats an enable on the same register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_o <= 4'b0000;
    end else begin
      vld_o[0] <= ifid_flush_o ? 1'b0 : (ifid_en_o ? 1'b1 : vld_o[0]);
      vld_o[1] <= idex_flush_o ? 1'b0 : (idex_en_o ? vld_o[0] : vld_o[1]);
      vld_o[2] <= exmem_flush_o ? 1'b0 : vld_o[1];
      vld_o[3] <= vld_o[2];
    end
  end

  // Saturating length of the current data-stall run.
  always_comb begin
    run_nxt = '0;
    if (is_data) begin
      run_nxt = (run_cnt == RUN_MAX) ? run_cnt : run_cnt + 1'b1;
    end
  end

  // Run counter and sticky hang flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      run_cnt <= '0;
      hang_o  <= 1'b0;
    end else begin
      run_cnt <= run_nxt;
      if (is_data && (run_nxt == RUN_MAX)) begin
        hang_o <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  // Free-running event counters, wrapping at 2^CNT_WIDTH.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o  <= '0;
      flush_cnt_o  <= '0;
      retire_cnt_o <= '0;
    end else begin
      if (is_data) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (is_ctrl) flush_cnt_o <= flush_cnt_o + 1'b1;
      if (vld_o[3]) retire_cnt_o <= retire_cnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized self-checking bench for hazard_ctrl against a behavioural model.
// Perf counter checks follow HAZARD_PERF_EN.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] stall;
  logic       pc_en, ifid_en, idex_en;
  logic       ifid_fl, idex_fl, exmem_fl;
  logic [3:0] vld;
  logic [1:0] st;
  logic       hang;
  logic       pc_en1, ifid_en1, idex_en1;
  logic       ifid_fl1, idex_fl1, exmem_fl1;
  logic [3:0] vld1;
  logic [1:0] st1;
  logic       hang1;
`ifdef HAZARD_PERF_EN
  logic [31:0] scnt, fcnt, rcnt;
  logic [31:0] scnt1, fcnt1, rcnt1;
`endif

  int checks = 0;
  int failures = 0;

  // model state: 0 run, 1 data stall, 2 control flush
  int          m_state;
  bit [3:0]    mv;
  int          mrun4, mrun1;
  bit          mh4, mh1;
  logic [31:0] mc_s, mc_f, mc_r;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_WIDTH(32), .MAX_STALL(4)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .idex_en_o(idex_en),
    .ifid_flush_o(ifid_fl), .idex_flush_o(idex_fl),
    .exmem_flush_o(exmem_fl), .vld_o(vld), .state_o(st),
    .hang_o(hang)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(scnt), .flush_cnt_o(fcnt), .retire_cnt_o(rcnt)
`endif
  );

  hazard_ctrl #(.CNT_WIDTH(32), .MAX_STALL(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .stall_i(stall),
    .pc_en_o(pc_en1), .ifid_en_o(ifid_en1), .idex_en_o(idex_en1),
    .ifid_flush_o(ifid_fl1), .idex_flush_o(idex_fl1),
    .exmem_flush_o(exmem_fl1), .vld_o(vld1), .state_o(st1),
    .hang_o(hang1)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(scnt1), .flush_cnt_o(fcnt1), .retire_cnt_o(rcnt1)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int eff_of(input logic [1:0] s);
    if (s == 2'b01 || s == 2'b11) return 1;
    if (s == 2'b10 && m_state != 2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; mv = 4'b0; mrun4 = 0; mrun1 = 0;
    mh4 = 0; mh1 = 0; mc_s = 0; mc_f = 0; mc_r = 0;
  endtask

  task automatic model_step(input logic [1:0] s);
    int e;
    bit [3:0] o;
    e = eff_of(s);
    o = mv;
    if (o[3]) mc_r = mc_r + 1;
    case (e)
      1: begin
        mv = {o[2], 1'b0, o[1], o[0]};
        mc_s = mc_s + 1;
        mrun4 = (mrun4 < 4) ? mrun4 + 1 : 4;
        mrun1 = 1;
      end
      2: begin
        mv = {o[2], o[1], 1'b0, 1'b0};
        mc_f = mc_f + 1;
        mrun4 = 0; mrun1 = 0;
      end
      default: begin
        mv = {o[2], o[1], o[0], 1'b1};
        mrun4 = 0; mrun1 = 0;
      end
    endcase
    if (mrun4 == 4) mh4 = 1;
    if (mrun1 == 1) mh1 = 1;
    m_state = e;
  endtask

  task automatic check_comb();
    int e;
    e = eff_of(stall);
    chk("pc_en", pc_en, e != 1);
    chk("ifid_en", ifid_en, e != 1);
    chk("idex_en", idex_en, e != 1);
    chk("ifid_flush", ifid_fl, e == 2);
    chk("idex_flush", idex_fl, e == 2);
    chk("exmem_flush", exmem_fl, e == 1);
  endtask

  task automatic check_regs();
    chk("state", st, m_state);
    chk("vld", vld, mv);
    chk("hang", hang, mh4);
    chk("hang_ms1", hang1, mh1);
`ifdef HAZARD_PERF_EN
    chk("stall_cnt", scnt, mc_s);
    chk("flush_cnt", fcnt, mc_f);
    chk("retire_cnt", rcnt, mc_r);
`endif
  endtask

  // one clock: apply hazard, check same-cycle controls, check state after edge
  task automatic cycle(input logic [1:0] s);
    stall = s;
    #1;
    check_comb();
    @(posedge clk);
    model_step(s);
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_state", st, 0);
    chk("rst_vld", vld, 0);
    chk("rst_hang", hang, 0);
  endtask

  initial begin
    logic [3:0] walk [5];
    walk = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
    stall = 2'b10;
    rst_n = 1'b0;
    model_reset();
    #12;
    chk("rst_state", st, 0);
    chk("rst_vld", vld, 0);
    chk("rst_hang", hang, 0);
    chk("rst_ctrl_flush", ifid_fl, 1);
    @(posedge clk);
    #1;
    chk("rst_hold_state", st, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      cycle(2'b00);
      chk("walk_vld", vld, walk[i]);
    end

    cycle(2'b01);
    chk("dstall_state", st, 1);
    chk("dstall_mem", vld[2], 0);
    cycle(2'b00);
    chk("dstall_wb", vld[3], 0);
    chk("hang1_one", hang1, 1);
    repeat (3) cycle(2'b00);

    cycle(2'b10);
    chk("cflush_state", st, 2);
    chk("cflush_vld", vld[1:0], 0);
    cycle(2'b10);
    chk("cflush_back", st, 0);
    repeat (3) cycle(2'b00);

    repeat (3) cycle(2'b01);
    chk("hang_3", hang, 0);
    cycle(2'b00);
    repeat (3) cycle(2'b01);
    cycle(2'b11);
    chk("hang_4", hang, 1);
    repeat (2) cycle(2'b00);
    chk("hang_sticky", hang, 1);

    cycle(2'b01);
    do_reset();
    stall = 2'b00;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(2'b10);
    cycle(2'b01);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2) begin
        do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end else if (r < 45) begin
        cycle(2'b00);
      end else if (r < 75) begin
        cycle(2'b01);
      end else if (r < 90) begin
        cycle(2'b10);
      end else begin
        cycle(2'b11);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
